// File: rtl/ar_id_ordering_queue_if.sv
// ar_if: AR channel bundle with receiver/sender views
interface ar_if #(
   parameter int ID_WIDTH   = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int LEN_WIDTH  = 8,
   parameter int USER_QOS_W = 4
);
   logic                  valid;
   logic                  ready;
   logic [ID_WIDTH-1:0]   id;
   logic [ADDR_WIDTH-1:0] addr;
   logic [LEN_WIDTH-1:0]  len;
   logic [2:0]            size;
   logic [1:0]            burst;
   logic [USER_QOS_W-1:0] qos;
   logic [ID_WIDTH-1:0]   tagid;
   modport receiver (input valid, id, addr, len, size, burst, qos, tagid, output ready);
   modport sender (output valid, id, addr, len, size, burst, qos, tagid, input ready);
endinterface

// File: rtl/ar_id_ordering_queue.sv
// ar_id_ordering_queue: in-order AR queue that remaps each head ARID through a unique-ID allocator; optional stat counters under AR_ORDER_STATS_EN
module ar_id_ordering_queue #(
   parameter int ID_WIDTH   = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int LEN_WIDTH  = 8,
   parameter int USER_QOS_W = 4,
   parameter int DEPTH      = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   ar_if.receiver                       ar_in,
   ar_if.sender                         ar_out,
   output logic                         alloc_req,
   input  logic                         alloc_gnt,
   output logic [ID_WIDTH-1:0]          alloc_in_id,
   input  logic [ID_WIDTH-1:0]          unique_id,
   input  logic                         tag_map_full,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy,
   output logic                         q_empty,
   output logic                         q_full,
   output logic [15:0]                  stat_accept_cnt,
   output logic [15:0]                  stat_issue_cnt,
   output logic [15:0]                  stat_stall_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int EW = ID_WIDTH + ADDR_WIDTH + LEN_WIDTH + 3 + 2 + USER_QOS_W;

   typedef enum logic [1:0] {H_IDLE, H_ALLOC, H_ISSUE} state_t;

   state_t              state, state_nx;
   logic [AW:0]         wr_ptr, rd_ptr, occ;
   logic [EW-1:0]       mem [DEPTH];
   logic [ID_WIDTH-1:0] head_id, uid_q;
   logic                run, hs_in, hs_out;

   assign occ             = wr_ptr - rd_ptr;
   assign occupancy       = occ;
   assign q_empty         = wr_ptr == rd_ptr;
   assign q_full          = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign ar_in.ready     = run & ~q_full & ~tag_map_full;
   assign hs_in           = ar_in.valid & ar_in.ready;
   assign hs_out          = ar_out.valid & ar_out.ready;
   assign alloc_req       = state == H_ALLOC;
   assign alloc_in_id     = head_id;
   assign ar_out.valid    = state == H_ISSUE;
   assign ar_out.id       = uid_q;
   assign ar_out.tagid    = uid_q;
   assign {head_id, ar_out.addr, ar_out.len, ar_out.size, ar_out.burst, ar_out.qos} = mem[rd_ptr[AW-1:0]];

   // Tail write; tagid is not stored since the allocator supplies the outgoing ID
   always_ff @(posedge clk)
      if (hs_in) mem[wr_ptr[AW-1:0]] <= {ar_in.id, ar_in.addr, ar_in.len, ar_in.size, ar_in.burst, ar_in.qos};

   // Pointers, head state, latched unique ID; run gates ready until the first edge out of reset
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state  <= H_IDLE;
         wr_ptr <= '0;
         rd_ptr <= '0;
         uid_q  <= '0;
         run    <= 1'b0;
      end else begin
         state <= state_nx;
         run   <= 1'b1;
         if (hs_in) wr_ptr <= wr_ptr + 1'b1;
         if (hs_out) rd_ptr <= rd_ptr + 1'b1;
         if (state == H_ALLOC && alloc_gnt) uid_q <= unique_id;
      end

   // Head sequencing: allocate, then issue; after issue re-allocate only if another entry will be waiting
   always_comb begin
      state_nx = state;
      state_nx = state == H_IDLE  ? ((|occ || hs_in) ? H_ALLOC : H_IDLE) :
                 state == H_ALLOC ? (alloc_gnt ? H_ISSUE : H_ALLOC) :
                 hs_out           ? ((|occ[AW:1] || hs_in) ? H_ALLOC : H_IDLE) : H_ISSUE;
   end

`ifdef AR_ORDER_STATS_EN
   // Saturating activity counters
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         stat_accept_cnt <= '0;
         stat_issue_cnt  <= '0;
         stat_stall_cnt  <= '0;
      end else begin
         if (hs_in && ~&stat_accept_cnt) stat_accept_cnt <= stat_accept_cnt + 1'b1;
         if (hs_out && ~&stat_issue_cnt) stat_issue_cnt <= stat_issue_cnt + 1'b1;
         if (ar_out.valid && !ar_out.ready && ~&stat_stall_cnt) stat_stall_cnt <= stat_stall_cnt + 1'b1;
      end
`else
   assign stat_accept_cnt = '0;
   assign stat_issue_cnt  = '0;
   assign stat_stall_cnt  = '0;
`endif
endmodule
